// File: rtl/bin_scheduler.sv
// Bin request scheduler: queues bin requests, launches them one at a time on the
// arithmetic decoder engine, times each operation and hands the decoded bin downstream.
//   IDLE  | no operation in flight, waiting for a queued request
//   ISSUE | head popped, operands on eng_*, eng_start high
//   WAIT  | engine running, cycle counter advancing
//   HOLD  | decoded bin presented on bin_out until bin_ready
module bin_scheduler #(
  parameter int DEPTH = 4,
  parameter int TMAX  = 127
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  input  logic       req_bypass,
  input  logic [5:0] req_ctx,
  output logic       req_ready,
  output logic       eng_start,
  output logic       eng_bypass,
  output logic [5:0] eng_ctx,
  input  logic       eng_done,
  input  logic       eng_bin,
  output logic       bin_valid,
  output logic       bin_out,
  input  logic       bin_ready,
  output logic [6:0] clock_cycle_count,
  output logic       timeout,
  output logic       busy
);

  localparam int              AW       = $clog2(DEPTH);
  localparam logic [AW-1:0]   PTR_ONE  = AW'(1);
  localparam logic [AW:0]     CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]     CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [6:0]      TMAX_C   = 7'(TMAX);
  localparam logic [6:0]      CNT_SAT  = 7'd127;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_e;

  state_e          state_q, state_d;
  logic [6:0]      fifo_mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic [6:0]      cnt_q, cnt_d;
  logic [6:0]      ccc_q, ccc_d;
  logic            bin_out_q, bin_out_d;
  logic            eng_bypass_q, eng_bypass_d;
  logic [5:0]      eng_ctx_q, eng_ctx_d;
  logic            full, empty, push, pop;
  logic [6:0]      head;

  assign full      = (count_q == CNT_FULL);
  assign empty     = (count_q == '0);
  // Gated by the reset pin so the FIFO refuses requests while reset is held.
  assign req_ready = reset & ~full;
  assign push      = req_valid & req_ready;
  assign pop       = (state_q == ISSUE);
  assign head      = fifo_mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem_q[wr_ptr_q] <= {req_bypass, req_ctx};
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    ccc_d        = ccc_q;
    bin_out_d    = bin_out_q;
    eng_bypass_d = eng_bypass_q;
    eng_ctx_d    = eng_ctx_q;
    timeout      = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          state_d                   = ISSUE;
          {eng_bypass_d, eng_ctx_d} = head;
        end
      end
      ISSUE: begin
        cnt_d   = 7'd1;
        state_d = WAIT;
      end
      WAIT: begin
        if (eng_done) begin
          bin_out_d = eng_bin;
          ccc_d     = cnt_q;
          state_d   = HOLD;
        end else if (cnt_q == TMAX_C) begin
          timeout = 1'b1;
          ccc_d   = TMAX_C;
          state_d = IDLE;
        end else if (cnt_q != CNT_SAT) begin
          cnt_d = cnt_q + 7'd1;
        end
      end
      HOLD: begin
        // Operands for the next request are staged here so eng_start follows without a gap.
        if (bin_ready) begin
          if (!empty) begin
            state_d                   = ISSUE;
            {eng_bypass_d, eng_ctx_d} = head;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      cnt_q        <= '0;
      ccc_q        <= '0;
      bin_out_q    <= 1'b0;
      eng_bypass_q <= 1'b0;
      eng_ctx_q    <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      cnt_q        <= cnt_d;
      ccc_q        <= ccc_d;
      bin_out_q    <= bin_out_d;
      eng_bypass_q <= eng_bypass_d;
      eng_ctx_q    <= eng_ctx_d;
    end
  end

  assign eng_start         = (state_q == ISSUE);
  assign bin_valid         = (state_q == HOLD);
  assign busy              = (state_q != IDLE) | ~empty;
  assign eng_bypass        = eng_bypass_q;
  assign eng_ctx           = eng_ctx_q;
  assign bin_out           = bin_out_q;
  assign clock_cycle_count = ccc_q;

endmodule

// File: tb/tb_bin_scheduler.sv
// Directed bench for bin_scheduler: a request-queue/engine model checked every cycle,
// plus literal expectations for the key scenarios.
module tb_bin_scheduler;

  localparam int DEPTH = 4;
  localparam int TMAX  = 10;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_valid, req_bypass;
  logic [5:0] req_ctx;
  logic       req_ready;
  logic       eng_start, eng_bypass;
  logic [5:0] eng_ctx;
  logic       eng_done, eng_bin;
  logic       bin_valid, bin_out, bin_ready;
  logic [6:0] clock_cycle_count;
  logic       timeout, busy;

  int n_total = 0;
  int n_bad   = 0;
  int n_start = 0;
  int eng_lat = 0;
  int spur_req = 0;
  int spur_ack = 0;
  logic spur_bin = 1'b0;

  always #5 clk = ~clk;

  bin_scheduler #(.DEPTH(DEPTH), .TMAX(TMAX)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_bypass(req_bypass), .req_ctx(req_ctx), .req_ready(req_ready),
    .eng_start(eng_start), .eng_bypass(eng_bypass), .eng_ctx(eng_ctx),
    .eng_done(eng_done), .eng_bin(eng_bin),
    .bin_valid(bin_valid), .bin_out(bin_out), .bin_ready(bin_ready),
    .clock_cycle_count(clock_cycle_count), .timeout(timeout), .busy(busy)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: queue of pending requests plus the life of the one outstanding engine job.
  localparam int M_IDLE = 0, M_LAUNCH = 1, M_RUN = 2, M_HOLD = 3;
  logic [6:0] mq[$];
  int         m_st  = M_IDLE;
  int         m_age = 0;
  logic [6:0] m_op  = '0;
  logic       m_bin = 1'b0;
  int         m_ccc = 0;

  task automatic model_step();
    bit acc;
    acc = req_valid && (mq.size() < DEPTH);
    case (m_st)
      M_IDLE:   if (mq.size() != 0) begin m_op = mq[0]; m_st = M_LAUNCH; end
      M_LAUNCH: begin void'(mq.pop_front()); m_age = 1; m_st = M_RUN; end
      M_RUN: begin
        if (eng_done) begin m_bin = eng_bin; m_ccc = m_age; m_st = M_HOLD; end
        else if (m_age == TMAX) begin m_ccc = TMAX; m_st = M_IDLE; end
        else if (m_age < 127) m_age++;
      end
      default: begin
        if (bin_ready) begin
          if (mq.size() != 0) begin m_op = mq[0]; m_st = M_LAUNCH; end
          else m_st = M_IDLE;
        end
      end
    endcase
    if (acc) mq.push_back({req_bypass, req_ctx});
  endtask

  initial begin
    forever begin
      @(negedge clk); #4;
      if (!reset) begin
        mq.delete(); m_st = M_IDLE; m_age = 0; m_op = '0; m_bin = 1'b0; m_ccc = 0;
      end
      chk("req_ready", 32'(req_ready), 32'(reset && (mq.size() < DEPTH)));
      chk("eng_start", 32'(eng_start), 32'(m_st == M_LAUNCH));
      chk("eng_bypass", 32'(eng_bypass), 32'(m_op[6]));
      chk("eng_ctx", 32'(eng_ctx), 32'(m_op[5:0]));
      chk("bin_valid", 32'(bin_valid), 32'(m_st == M_HOLD));
      chk("bin_out", 32'(bin_out), 32'(m_bin));
      chk("cycle_count", 32'(clock_cycle_count), 32'(m_ccc));
      chk("timeout", 32'(timeout), 32'(m_st == M_RUN && m_age == TMAX && !eng_done));
      chk("busy", 32'(busy), 32'(m_st != M_IDLE || mq.size() != 0));
      @(posedge clk);
      if (reset) model_step();
    end
  end

  // Engine stand-in: completes eng_lat cycles after each start (never if 0), bin = ctx LSB.
  initial begin
    int   pend = 0;
    logic pend_bin = 1'b0;
    eng_done = 1'b0;
    eng_bin  = 1'b0;
    forever begin
      @(negedge clk);
      eng_done = 1'b0;
      if (eng_start) n_start++;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin eng_done = 1'b1; eng_bin = pend_bin; end
      end
      if (spur_req != spur_ack) begin
        spur_ack = spur_req; eng_done = 1'b1; eng_bin = spur_bin;
      end
      if (eng_start && eng_lat > 0) begin pend = eng_lat; pend_bin = eng_ctx[0]; end
    end
  end

  task automatic push(input logic b, input logic [5:0] c);
    bit acc = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_bypass = b; req_ctx = c;
    for (int i = 0; i < 50 && !acc; i++) begin
      #4 acc = req_ready;
      if (!acc) @(negedge clk);
    end
    chk("push_accept", 32'(acc), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_bin();
    int i = 0;
    while (!bin_valid && i < 200) begin @(posedge clk); #1; i++; end
    chk("wait_bin_valid", 32'(bin_valid), 32'd1);
  endtask

  task automatic wait_start();
    int i = 0;
    while (!eng_start && i < 200) begin @(posedge clk); #1; i++; end
    chk("wait_eng_start", 32'(eng_start), 32'd1);
  endtask

  task automatic ack();
    @(negedge clk) bin_ready = 1'b1;
    @(negedge clk) bin_ready = 1'b0;
  endtask

  task automatic drain(input int n, input int base);
    for (int k = 0; k < n; k++) begin
      wait_bin();
      chk("drain_ctx", 32'(eng_ctx), 32'(base + k));
      chk("drain_bin", 32'(bin_out), 32'((base + k) % 2));
      chk("drain_ccc", 32'(clock_cycle_count), 32'(eng_lat));
      ack();
    end
  endtask

  initial begin
    int i;
    reset = 1'b0; req_valid = 1'b0; req_bypass = 1'b0; req_ctx = '0; bin_ready = 1'b0;
    repeat (3) @(negedge clk);
    #4 chk("rst_req_ready", 32'(req_ready), 32'd0);
    @(negedge clk) reset = 1'b1;
    #4 chk("rel_req_ready", 32'(req_ready), 32'd1);

    // single request, engine done 3 cycles after start
    eng_lat = 3;
    push(1'b1, 6'd5);
    wait_bin();
    chk("t1_bin_out", 32'(bin_out), 32'd1);
    chk("t1_ccc", 32'(clock_cycle_count), 32'd3);
    chk("t1_ctx", 32'(eng_ctx), 32'd5);
    chk("t1_bypass", 32'(eng_bypass), 32'd1);
    chk("t1_starts", 32'(n_start), 32'd1);
    ack();

    // fill the FIFO behind a held result, then drain in order
    eng_lat = 1;
    push(1'b0, 6'd1); push(1'b1, 6'd2); push(1'b0, 6'd3); push(1'b1, 6'd4); push(1'b0, 6'd5);
    chk("t2_full_ready", 32'(req_ready), 32'd0);
    drain(5, 1);
    #4 chk("t2_starts", 32'(n_start), 32'd6);

    // engine never responds: timeout, then next request issues
    eng_lat = 0;
    push(1'b1, 6'd9); push(1'b0, 6'd10);
    wait_start();
    i = 0;
    do begin @(posedge clk); #1; i++; end while (!timeout && i < 50);
    chk("t3_timeout_cycle", 32'(i), 32'd10);
    chk("t3_no_valid", 32'(bin_valid), 32'd0);
    @(negedge clk) eng_lat = 2;
    @(posedge clk); #1;
    chk("t3_ccc_tmax", 32'(clock_cycle_count), 32'd10);
    chk("t3_pulse_end", 32'(timeout), 32'd0);
    wait_bin();
    chk("t3_next_ctx", 32'(eng_ctx), 32'd10);
    chk("t3_next_ccc", 32'(clock_cycle_count), 32'd2);
    ack();

    // push and pop in the same cycle at occupancy 2, across pointer wrap
    eng_lat = 1;
    push(1'b0, 6'd20);
    wait_bin();
    chk("t4_first_ctx", 32'(eng_ctx), 32'd20);
    push(1'b1, 6'd21); push(1'b0, 6'd22);
    @(negedge clk) bin_ready = 1'b1;
    @(negedge clk) begin bin_ready = 1'b0; req_valid = 1'b1; req_bypass = 1'b1; req_ctx = 6'd23; end
    #4 chk("t4_ready_at_pop", 32'(req_ready), 32'd1);
    @(negedge clk) req_valid = 1'b0;
    push(1'b1, 6'd24);
    chk("t4_ready_occ3", 32'(req_ready), 32'd1);
    push(1'b0, 6'd25);
    chk("t4_ready_full", 32'(req_ready), 32'd0);
    drain(5, 21);

    // spurious eng_done in IDLE and in HOLD
    @(negedge clk) begin spur_bin = 1'b0; spur_req++; end
    repeat (4) @(negedge clk);
    #4;
    chk("t5_idle_bin_out", 32'(bin_out), 32'd1);
    chk("t5_idle_valid", 32'(bin_valid), 32'd0);
    chk("t5_idle_busy", 32'(busy), 32'd0);
    eng_lat = 2;
    push(1'b0, 6'd30);
    wait_bin();
    @(negedge clk) begin spur_bin = 1'b1; spur_req++; end
    repeat (4) @(negedge clk);
    #4;
    chk("t5_hold_bin_out", 32'(bin_out), 32'd0);
    chk("t5_hold_valid", 32'(bin_valid), 32'd1);
    chk("t5_hold_ctx", 32'(eng_ctx), 32'd30);
    chk("t5_hold_ccc", 32'(clock_cycle_count), 32'd2);
    ack();

    // reset while WAIT with two queued requests; engine answers late
    eng_lat = 8;
    push(1'b1, 6'd40); push(1'b0, 6'd41); push(1'b1, 6'd42);
    @(negedge clk) reset = 1'b0;
    #4;
    chk("t6_rst_start", 32'(eng_start), 32'd0);
    chk("t6_rst_bypass", 32'(eng_bypass), 32'd0);
    chk("t6_rst_ctx", 32'(eng_ctx), 32'd0);
    chk("t6_rst_valid", 32'(bin_valid), 32'd0);
    chk("t6_rst_bin", 32'(bin_out), 32'd0);
    chk("t6_rst_ccc", 32'(clock_cycle_count), 32'd0);
    chk("t6_rst_timeout", 32'(timeout), 32'd0);
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_ready", 32'(req_ready), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #4;
    chk("t6_rel_busy", 32'(busy), 32'd0);
    chk("t6_rel_ready", 32'(req_ready), 32'd1);
    repeat (10) @(negedge clk);
    #4;
    chk("t6_late_valid", 32'(bin_valid), 32'd0);
    chk("t6_late_busy", 32'(busy), 32'd0);
    chk("t6_late_ccc", 32'(clock_cycle_count), 32'd0);

    eng_lat = 1;
    push(1'b1, 6'd50);
    drain(1, 50);
    #4 chk("total_starts", 32'(n_start), 32'd17);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, bad=%0d", n_bad);
    $fatal(1, "watchdog");
  end

endmodule
